// File: rtl/register_serializer_pkg.sv
// Shared types and sizing helpers for the register serializer.
package register_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int unsigned DEFAULT_WIDTH = 32;

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/register_serializer_if.sv
// Parallel load and 1-bit valid/ready serial link for the register serializer.
interface register_serializer_if
  import register_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
);
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             E;
  logic             Busy;
  logic             SerOut;
  logic             SerValid;
  logic             SerReady;
  logic             Done;

  modport master (
    output D, E, SerReady,
    input  Q, Busy, SerOut, SerValid, Done
  );

  modport slave (
    input  D, E, SerReady,
    output Q, Busy, SerOut, SerValid, Done
  );
endinterface

// File: rtl/register_serializer_bit_counter.sv
// Sync-reset up-counter that saturates at WIDTH-1 and flags the terminal value.
module bit_counter
  import register_serializer_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic                        Clock,
  input  logic                        Reset,
  input  logic                        clear,
  input  logic                        inc,
  output logic [cnt_width(WIDTH)-1:0] count,
  output logic                        last
);
  localparam int unsigned CW = cnt_width(WIDTH);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign last  = (count_q == CW'(WIDTH - 1));
  assign count = count_q;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (inc && !last) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/register_serializer.sv
// Captures a word on a load strobe and streams it out one bit per valid/ready handshake.
module register_serializer
  import register_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DEFAULT_WIDTH,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic                  Clock,
  input  logic                  Reset,
  register_serializer_if.slave  bus
);
  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             done_q, done_d;

  logic [CW-1:0]    count;
  logic             last;
  logic             clear;
  logic             inc;

  bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .Clock (Clock),
    .Reset (Reset),
    .clear (clear),
    .inc   (inc),
    .count (count),
    .last  (last)
  );

  // The output end of the shift register is the serial bit itself, so SerOut is
  // a flop output and reads 0 whenever the register has been drained or reset.
  assign bus.SerOut   = MSB_FIRST ? shift_q[WIDTH-1] : shift_q[0];
  assign bus.Q        = q_q;
  assign bus.Busy     = busy_q;
  assign bus.SerValid = valid_q;
  assign bus.Done     = done_q;

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    q_d     = q_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    clear   = 1'b0;
    inc     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.E) begin
          state_d = SHIFT;
          shift_d = bus.D;
          q_d     = bus.D;
          busy_d  = 1'b1;
          valid_d = 1'b1;
          clear   = 1'b1;
        end
      end
      SHIFT: begin
        if (valid_q && bus.SerReady) begin
          inc = 1'b1;
          if (last) begin
            state_d = IDLE;
            shift_d = '0;
            busy_d  = 1'b0;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (MSB_FIRST) begin
            shift_d = {shift_q[WIDTH-2:0], 1'b0};
          end else begin
            shift_d = {1'b0, shift_q[WIDTH-1:1]};
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      q_q     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      q_q     <= q_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (!Reset) begin
      a_count_range: assert (count <= CW'(WIDTH - 1));
    end
  end
endmodule

// File: tb/tb_register_serializer.sv
// Scoreboard bench: stimulus queues expected bits/Done pulses, a monitor checks handshakes.
module tb_register_serializer;
  import register_serializer_pkg::*;

  localparam int unsigned W = 32;

  logic Clock = 1'b0;
  logic Reset = 1'b1;

  register_serializer_if #(.WIDTH(W)) bus ();

  register_serializer #(.WIDTH(W), .MSB_FIRST(1'b1)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  int   checks    = 0;
  int   errors    = 0;
  logic exp_q[$];
  int   exp_done  = 0;
  int   hs_count  = 0;
  logic stalled   = 1'b0;
  logic held      = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push_word(input logic [W-1:0] w);
    for (int i = W - 1; i >= 0; i--) exp_q.push_back(w[i]);
    exp_done++;
  endtask

  task automatic load(input logic [W-1:0] w);
    @(posedge Clock); #1;
    bus.D = w;
    bus.E = 1'b1;
    push_word(w);
    @(posedge Clock); #1;
    bus.E = 1'b0;
  endtask

  // Entered just after a rising edge; returns at the falling edge of the Done cycle.
  task automatic wait_done(input bit bp, input int max, output int cycles, output bit found);
    logic [15:0] pat;
    pat    = 16'b0100_1101_0010_1001;
    found  = 1'b0;
    cycles = 0;
    while (cycles < max && !found) begin
      bus.SerReady = bp ? pat[cycles % 16] : 1'b1;
      cycles++;
      @(negedge Clock);
      if (bus.Done) found = 1'b1;
      else begin
        @(posedge Clock); #1;
      end
    end
    chk("done_seen", found, 1);
    bus.SerReady = 1'b1;
  endtask

  // Monitor: pops one expected bit per handshake, one expected pulse per Done.
  initial begin
    forever begin
      @(negedge Clock);
      if (Reset) begin
        stalled = 1'b0;
      end else begin
        if (stalled && bus.SerValid) chk("stall_hold", bus.SerOut, held);
        stalled = bus.SerValid && !bus.SerReady;
        held    = bus.SerOut;
        if (bus.SerValid && bus.SerReady) begin
          chk("bit_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) chk("serout", bus.SerOut, exp_q.pop_front());
          hs_count++;
        end
        if (bus.Done) begin
          chk("done_expected", exp_done > 0, 1);
          if (exp_done > 0) exp_done--;
          chk("done_hs_count", hs_count, W);
          hs_count = 0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int cycles;
    bit found;
    bus.D        = '0;
    bus.E        = 1'b0;
    bus.SerReady = 1'b1;

    // 1. Reset then idle
    repeat (2) @(posedge Clock);
    #1 Reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge Clock);
      chk("idle_q", bus.Q, 0);
      chk("idle_busy", bus.Busy, 0);
      chk("idle_valid", bus.SerValid, 0);
      chk("idle_done", bus.Done, 0);
      chk("idle_serout", bus.SerOut, 0);
    end

    // 2. MSB-first stream, SerReady held high
    load(32'hA5A5_0F0F);
    chk("busy_after_load", bus.Busy, 1);
    chk("first_bit", bus.SerOut, 1);
    wait_done(1'b0, 100, cycles, found);
    chk("latency_done", cycles, 33);
    chk("q_a5a5", bus.Q, 32'hA5A5_0F0F);
    chk("done_busy", bus.Busy, 0);
    chk("done_valid", bus.SerValid, 0);
    @(negedge Clock);
    chk("done_one_cycle", bus.Done, 0);

    // 3. Backpressure
    load(32'h8000_0001);
    wait_done(1'b1, 300, cycles, found);
    chk("q_bp", bus.Q, 32'h8000_0001);

    // 4. E during Busy is ignored
    load(32'hFFFF_FFFF);
    repeat (5) @(posedge Clock);
    #1;
    bus.D = 32'h1234_5678;
    bus.E = 1'b1;
    @(posedge Clock); #1;
    bus.E = 1'b0;
    chk("q_hold_mid", bus.Q, 32'hFFFF_FFFF);
    wait_done(1'b0, 100, cycles, found);
    chk("latency_ignore_e", cycles, 27);
    chk("q_hold_end", bus.Q, 32'hFFFF_FFFF);

    // 5. Back-to-back load in the Done cycle
    load(32'h0000_0001);
    wait_done(1'b0, 100, cycles, found);
    chk("latency_b2b_first", cycles, 33);
    bus.D = 32'h8000_0000;
    bus.E = 1'b1;
    push_word(32'h8000_0000);
    @(posedge Clock); #1;
    bus.E = 1'b0;
    @(negedge Clock);
    chk("b2b_valid", bus.SerValid, 1);
    chk("b2b_done_low", bus.Done, 0);
    chk("b2b_first_bit", bus.SerOut, 1);
    @(posedge Clock); #1;
    wait_done(1'b0, 100, cycles, found);
    chk("latency_b2b_second", cycles, 32);
    chk("q_b2b", bus.Q, 32'h8000_0000);

    // 6. Reset mid-transfer
    load(32'hDEAD_BEEF);
    repeat (10) @(posedge Clock);
    #1;
    chk("hs_before_reset", hs_count, 10);
    Reset = 1'b1;
    exp_q.delete();
    exp_done = 0;
    hs_count = 0;
    @(posedge Clock); #1;
    Reset = 1'b0;
    @(negedge Clock);
    chk("rst_q", bus.Q, 0);
    chk("rst_busy", bus.Busy, 0);
    chk("rst_valid", bus.SerValid, 0);
    chk("rst_serout", bus.SerOut, 0);
    chk("rst_done", bus.Done, 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge Clock);
      chk("no_done_after_rst", bus.Done, 0);
    end
    load(32'hDEAD_BEEF);
    chk("fresh_first_bit", bus.SerOut, 1);
    wait_done(1'b0, 100, cycles, found);
    chk("latency_fresh", cycles, 33);
    chk("q_fresh", bus.Q, 32'hDEAD_BEEF);

    repeat (3) @(negedge Clock);
    chk("leftover_bits", exp_q.size(), 0);
    chk("leftover_done", exp_done, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
